muladd_arbiter: RTL and testbench
=================================

MULADD_ARBITER -- requirements
Module: muladd_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing the multiply-add unit (2..8).
REQ-002 SHALL have parameter DWIDTH1, default 16: signed operand a width.
REQ-003 SHALL have parameter DWIDTH2, default 16: signed operand b width.
REQ-004 SHALL have parameter DWIDTH, default 32: addend c and result width.
REQ-005 SHALL have port clk  in  1: the single clock; all state on its rising edge.
REQ-006 SHALL have port Reset  in  1: asynchronous, active-high reset.
REQ-007 SHALL have port req_valid  in  NREQ: per-requester operation request.
REQ-008 SHALL have port req_a  in  NREQ*DWIDTH1: packed operand a, requester i at slice i.
REQ-009 SHALL have port req_b  in  NREQ*DWIDTH2: packed operand b.
REQ-010 SHALL have port req_c  in  NREQ*DWIDTH: packed addend c.
REQ-011 SHALL have port req_sub  in  NREQ: 1 = a*b-c, 0 = a*b+c.
REQ-012 SHALL have port req_ready  out  NREQ: one-hot grant; transfer when req_valid[i] & req_ready[i].
REQ-013 SHALL have port rsp_valid  out  NREQ: one-hot result strobe for the owning requester.
REQ-014 SHALL have port rsp_data  out  DWIDTH: result, meaningful only while any rsp_valid bit is set.
REQ-015 SHALL have port busy  out  1: high while any accepted operation is still in flight.

Function
REQ-016 SHALL grant at most one requester per cycle, combinationally from req_valid and the round-robin pointer.
REQ-017 SHALL grant the first valid requester at or after the pointer, searching upward with wrap from NREQ-1 to 0.
REQ-018 SHALL set the pointer to (granted index + 1) mod NREQ after each transfer; no transfer leaves it unchanged.
REQ-019 SHALL assert req_ready for no requester when no req_valid bit is set.
REQ-020 SHALL accept one operation per cycle with no bubbles; the pipeline never stalls.
REQ-021 SHALL compute rsp_data = sign-extended signed(a)*signed(b) +/- c, modulo 2^DWIDTH, with c treated as unsigned.
REQ-022 SHALL present the result exactly 3 cycles after transfer: operands registered in cycle 1, product in cycle 2, add/sub in cycle 3.
REQ-023 SHALL carry a requester tag and valid bit alongside each pipeline stage; rsp_valid is the one-hot decode of the stage-3 tag.
REQ-024 SHALL keep rsp_data unchanged while no result is valid.
REQ-025 SHALL derive busy from the OR of the three stage-valid bits.
REQ-026 SHALL let a requester withdraw req_valid at any time before transfer without side effects.

Reset
REQ-027 SHALL on Reset clear the pointer to 0, all stage-valid bits, tags and data registers, and drive rsp_valid=0, rsp_data=0 and busy=0.
REQ-028 SHALL discard in-flight operations on Reset mid-operation, with no rsp_valid for them after release.
REQ-029 SHALL drive req_ready=0 while Reset is high.

Configuration
REQ-030 SHALL support macro MULADD_ARB_LOCK_EN; when defined, it adds input req_lock (NREQ).
REQ-031 SHALL with MULADD_ARB_LOCK_EN keep granting requester i without pointer advance while req_valid[i] & req_lock[i] after a transfer from i.
REQ-032 SHALL with MULADD_ARB_LOCK_EN release the lock when i drops req_valid or req_lock, then resume round-robin from (i+1) mod NREQ.
REQ-033 SHALL without MULADD_ARB_LOCK_EN have no req_lock port and pure round-robin behaviour.

Structure
REQ-034 SHALL place pipeline latency constant (3), tag-width function clog2(NREQ) and stage record typedef (valid, tag, sub) in shared package muladd_pkg.
REQ-035 SHALL implement the arithmetic in one sub-module, muladd_pipe: 3-stage, async active-high reset, tag carried through it.

Verification
REQ-036 SHALL cover a single request: req0 a=3, b=-4, c=10, sub=0 -> rsp_valid=0001, rsp_data=-2 (0xFFFFFFFE) 3 cycles after transfer.
REQ-037 SHALL cover subtract wrap: a=0x7FFF, b=0x7FFF, c=0x40000000, sub=1 -> rsp_data=0xFFFF0001.
REQ-038 SHALL cover all four requesters valid continuously from reset -> grant order 0,1,2,3,0; one result per cycle in that order; busy high throughout.
REQ-039 SHALL cover Reset pulsed with 2 operations in flight -> no rsp_valid afterwards, busy=0, next grant goes to requester 0.
REQ-040 SHALL cover, with MULADD_ARB_LOCK_EN, req1 locked for 3 ops while req2 is valid -> grants 1,1,1,2.

Source files
------------

// File: rtl/muladd_pkg.sv
// rtl/muladd_pkg.sv - shared constants, tag-width helper and pipeline stage record for muladd_arbiter
package muladd_pkg;

    // Cycles from transfer to result
    localparam int LATENCY   = 3;

    // Widest tag ever needed (NREQ is at most 8)
    localparam int TAG_MAX_W = 3;

    // Bits needed to index n requesters, never less than one
    function automatic int clog2(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Control record travelling alongside the data in every pipeline stage
    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic                 sub;
    } stage_t;

endpackage

// File: rtl/muladd_arbiter_if.sv
// rtl/muladd_arbiter_if.sv - requester/response bundle; MULADD_ARB_LOCK_EN adds req_lock
interface muladd_arbiter_if #(
    parameter int NREQ    = 4,
    parameter int DWIDTH1 = 16,
    parameter int DWIDTH2 = 16,
    parameter int DWIDTH  = 32
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*DWIDTH1-1:0] req_a;
    logic [NREQ*DWIDTH2-1:0] req_b;
    logic [NREQ*DWIDTH-1:0]  req_c;
    logic [NREQ-1:0]         req_sub;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0]         rsp_valid;
    logic [DWIDTH-1:0]       rsp_data;
    logic                    busy;
`ifdef MULADD_ARB_LOCK_EN
    logic [NREQ-1:0]         req_lock;

    modport master (
        output req_valid, req_a, req_b, req_c, req_sub, req_lock,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c, req_sub, req_lock,
        output req_ready, rsp_valid, rsp_data, busy
    );
`else
    modport master (
        output req_valid, req_a, req_b, req_c, req_sub,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c, req_sub,
        output req_ready, rsp_valid, rsp_data, busy
    );
`endif
endinterface

// File: rtl/muladd_pipe.sv
// rtl/muladd_pipe.sv - three-stage signed multiply then add/subtract, tag carried alongside
module muladd_pipe
    import muladd_pkg::*;
#(
    parameter int DWIDTH1 = 16,
    parameter int DWIDTH2 = 16,
    parameter int DWIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  stage_t                    in_stage,
    input  logic signed [DWIDTH1-1:0] in_a,
    input  logic signed [DWIDTH2-1:0] in_b,
    input  logic [DWIDTH-1:0]         in_c,
    output stage_t                    out_stage,
    output logic [DWIDTH-1:0]         out_data,
    output logic                      busy
);
    localparam int PWIDTH = DWIDTH1 + DWIDTH2;

    stage_t                    st [LATENCY];
    logic signed [DWIDTH1-1:0] a1;
    logic signed [DWIDTH2-1:0] b1;
    logic [DWIDTH-1:0]         c1;
    logic [DWIDTH-1:0]         c2;
    logic signed [PWIDTH-1:0]  prod2;
    logic [DWIDTH-1:0]         prod_ext;
    logic [DWIDTH-1:0]         res3;

    // Product sign-extended (or truncated) to the result width
    assign prod_ext = DWIDTH'(prod2);

    // Control records shift one stage per clock; the pipeline never stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                st[i] <= '0;
            end
        end else begin
            st[0] <= in_stage;
            for (int i = 1; i < LATENCY; i++) begin
                st[i] <= st[i-1];
            end
        end
    end

    // Data stages only load behind a valid record so the result holds while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a1    <= '0;
            b1    <= '0;
            c1    <= '0;
            c2    <= '0;
            prod2 <= '0;
            res3  <= '0;
        end else begin
            if (in_stage.valid) begin
                a1 <= in_a;
                b1 <= in_b;
                c1 <= in_c;
            end
            if (st[0].valid) begin
                prod2 <= PWIDTH'(a1) * PWIDTH'(b1);
                c2    <= c1;
            end
            if (st[1].valid) begin
                res3 <= st[1].sub ? (prod_ext - c2) : (prod_ext + c2);
            end
        end
    end

    // Busy whenever any stage holds a live operation
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            busy = busy | st[i].valid;
        end
    end

    assign out_stage = st[LATENCY-1];
    assign out_data  = res3;

endmodule

// File: rtl/muladd_arbiter.sv
// rtl/muladd_arbiter.sv - round-robin arbiter sharing one multiply-add pipe; MULADD_ARB_LOCK_EN adds grant locking
module muladd_arbiter
    import muladd_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DWIDTH1 = 16,
    parameter int DWIDTH2 = 16,
    parameter int DWIDTH  = 32
) (
    input  logic           clk,
    input  logic           Reset,
    muladd_arbiter_if.slave bus
);
    localparam int TW = clog2(NREQ);

    logic [TW-1:0]             ptr;
    logic [TW-1:0]             ptr_next;
    logic [TW-1:0]             gidx;
    logic [NREQ-1:0]           grant;
    logic                      transfer;
    logic signed [DWIDTH1-1:0] a_sel;
    logic signed [DWIDTH2-1:0] b_sel;
    logic [DWIDTH-1:0]         c_sel;
    logic                      sub_sel;
    stage_t                    in_stage;
    stage_t                    out_stage;
    logic [DWIDTH-1:0]         data;
    logic                      busy;
    logic [NREQ-1:0]           rsp_valid;
`ifdef MULADD_ARB_LOCK_EN
    logic                      locked;
    logic [TW-1:0]             lock_idx;
`endif

    // Grant the first valid requester at or after the pointer; a held lock overrides
    always_comb begin
        int            idx;
        logic [TW-1:0] sel;
        grant = '0;
        gidx  = '0;
        idx   = 0;
        sel   = '0;
        // Descending scan so the nearest candidate to the pointer is written last
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            sel = TW'(idx);
            if (bus.req_valid[sel]) begin
                grant      = '0;
                grant[sel] = 1'b1;
                gidx       = sel;
            end
        end
`ifdef MULADD_ARB_LOCK_EN
        if (locked && bus.req_valid[lock_idx] && bus.req_lock[lock_idx]) begin
            grant           = '0;
            grant[lock_idx] = 1'b1;
            gidx            = lock_idx;
        end
`endif
        if (Reset) begin
            grant = '0;
        end
    end

    assign transfer = |grant;
    assign ptr_next = (gidx == TW'(NREQ - 1)) ? '0 : gidx + 1'b1;

    // Pointer moves past the winner on every transfer and holds otherwise
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            ptr <= '0;
        end else if (transfer) begin
            ptr <= ptr_next;
        end
    end

`ifdef MULADD_ARB_LOCK_EN
    // Lock stays armed only while the winner keeps both valid and lock raised
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            locked   <= 1'b0;
            lock_idx <= '0;
        end else begin
            locked   <= transfer & bus.req_lock[gidx];
            lock_idx <= gidx;
        end
    end
`endif

    // Operand mux driven straight from the one-hot grant
    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        c_sel   = '0;
        sub_sel = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                a_sel   = bus.req_a[i*DWIDTH1 +: DWIDTH1];
                b_sel   = bus.req_b[i*DWIDTH2 +: DWIDTH2];
                c_sel   = bus.req_c[i*DWIDTH +: DWIDTH];
                sub_sel = bus.req_sub[i];
            end
        end
    end

    assign in_stage.valid = transfer;
    assign in_stage.tag   = TAG_MAX_W'(gidx);
    assign in_stage.sub   = sub_sel;

    muladd_pipe #(
        .DWIDTH1 (DWIDTH1),
        .DWIDTH2 (DWIDTH2),
        .DWIDTH  (DWIDTH)
    ) u_pipe (
        .clk       (clk),
        .rst       (Reset),
        .in_stage  (in_stage),
        .in_a      (a_sel),
        .in_b      (b_sel),
        .in_c      (c_sel),
        .out_stage (out_stage),
        .out_data  (data),
        .busy      (busy)
    );

    // Result strobe is the one-hot decode of the final-stage tag
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = out_stage.valid && (out_stage.tag == TAG_MAX_W'(i));
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = data;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_muladd_arbiter.sv
// tb/tb_muladd_arbiter.sv - scoreboard bench for muladd_arbiter; lock scenario under MULADD_ARB_LOCK_EN
module tb_muladd_arbiter;

    logic clk;
    logic rst;

    muladd_arbiter_if #(.NREQ(4), .DWIDTH1(16), .DWIDTH2(16), .DWIDTH(32)) bus ();

    muladd_arbiter #(.NREQ(4), .DWIDTH1(16), .DWIDTH2(16), .DWIDTH(32)) dut (
        .clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  oh;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        rsp_q[$];
    logic [15:0] a_v [4];
    logic [15:0] b_v [4];
    logic [31:0] c_v [4];
    logic [31:0] exp_tab [4];
    int          exp_grant [64];
    int          exp_grant_n;
    int          grant_rd;
    int          cyc;
    int          checks;
    int          failures;
    int          chk_mode;
    logic [31:0] chk_val;

    assign bus.req_a = {a_v[3], a_v[2], a_v[1], a_v[0]};
    assign bus.req_b = {b_v[3], b_v[2], b_v[1], b_v[0]};
    assign bus.req_c = {c_v[3], c_v[2], c_v[1], c_v[0]};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: records accepted transfers, checks grants and responses against the scoreboard
    always @(negedge clk) begin
        int   idx;
        exp_t e;
        idx = 0;
        if (rst) begin
            rsp_q.delete();
            if (chk_mode == 1) begin
                chk("rst_req_ready", bus.req_ready, 0);
                chk("rst_rsp_valid", bus.rsp_valid, 0);
                chk("rst_rsp_data", bus.rsp_data, 0);
                chk("rst_busy", bus.busy, 0);
            end
        end else begin
            if ((bus.req_ready & ~bus.req_valid) != 4'b0000) begin
                chk("ready_without_valid", bus.req_ready & ~bus.req_valid, 0);
            end
            if ((bus.req_valid & bus.req_ready) != 4'b0000) begin
                chk("grant_onehot", $onehot(bus.req_ready), 1);
                for (int i = 0; i < 4; i++) begin
                    if (bus.req_ready[i]) idx = i;
                end
                if (grant_rd < exp_grant_n) begin
                    chk("grant_index", idx, exp_grant[grant_rd]);
                    grant_rd = grant_rd + 1;
                end else begin
                    chk("grant_unexpected", idx, 32'hFFFF_FFFF);
                end
                rsp_q.push_back('{oh: bus.req_ready, data: exp_tab[idx], cyc: cyc + 3});
            end
            if (bus.rsp_valid != 4'b0000) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", bus.rsp_valid, 0);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_valid", bus.rsp_valid, e.oh);
                    chk("rsp_data", bus.rsp_data, e.data);
                    chk("rsp_cycle", cyc, e.cyc);
                end
            end
            case (chk_mode)
                2: chk("busy", bus.busy, chk_val[0]);
                3: chk("rsp_data_hold", bus.rsp_data, chk_val);
                4: begin
                    chk("quiet_rsp_valid", bus.rsp_valid, 0);
                    chk("quiet_busy", bus.busy, 0);
                end
                5: begin
                    chk("rsp_q_drained", rsp_q.size(), 0);
                    chk("grants_seen", grant_rd, exp_grant_n);
                end
                default: ;
            endcase
        end
    end

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] c, input logic sub, input logic [31:0] exp);
        a_v[i]         = a;
        b_v[i]         = b;
        c_v[i]         = c;
        bus.req_sub[i] = sub;
        exp_tab[i]     = exp;
    endtask

    task automatic expect_grant(input int i);
        exp_grant[exp_grant_n] = i;
        exp_grant_n = exp_grant_n + 1;
    endtask

    task automatic drive(input logic [3:0] m, input int n);
        @(posedge clk); #1;
        bus.req_valid = m;
        repeat (n) begin
            @(posedge clk); #1;
        end
        bus.req_valid = 4'b0000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic probe(input int mode, input logic [31:0] val);
        @(posedge clk); #1;
        chk_mode = mode;
        chk_val  = val;
        @(negedge clk); #1;
        chk_mode = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        rst      = 1'b1;
        chk_mode = 1;
        repeat (2) @(negedge clk);
        #1 chk_mode = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc         = 0;
        checks      = 0;
        failures    = 0;
        chk_mode    = 0;
        chk_val     = '0;
        exp_grant_n = 0;
        grant_rd    = 0;
        for (int i = 0; i < 4; i++) begin
            a_v[i] = '0; b_v[i] = '0; c_v[i] = '0; exp_tab[i] = '0;
        end
        bus.req_sub   = 4'b0000;
`ifdef MULADD_ARB_LOCK_EN
        bus.req_lock  = 4'b0000;
`endif
        // Reset with every requester asking: no grant may escape
        rst           = 1'b1;
        bus.req_valid = 4'b1111;
        chk_mode      = 1;
        repeat (2) @(negedge clk);
        #1 chk_mode = 0;
        bus.req_valid = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b0;

        // Single request: 3*-4+10 = -2
        set_req(0, 16'd3, 16'hFFFC, 32'd10, 1'b0, 32'hFFFF_FFFE);
        expect_grant(0);
        drive(4'b0001, 1);
        idle(5);
        probe(3, 32'hFFFF_FFFE);
        probe(2, 32'd0);

        // Subtract wrap; pointer is at 1 so requester 0 is found by wrapping
        set_req(0, 16'h7FFF, 16'h7FFF, 32'h4000_0000, 1'b1, 32'hFFFF_0001);
        expect_grant(0);
        drive(4'b0001, 1);
        // -3*7-5 = -26
        set_req(2, 16'hFFFD, 16'd7, 32'd5, 1'b1, 32'hFFFF_FFE6);
        expect_grant(2);
        drive(4'b0100, 1);
        // Contention from pointer 3: 0 then 1
        set_req(0, 16'd1, 16'd2, 32'd3, 1'b0, 32'd5);
        set_req(1, 16'hFFFF, 16'd5, 32'd0, 1'b1, 32'hFFFF_FFFB);
        expect_grant(0);
        expect_grant(1);
        drive(4'b0011, 2);
        idle(6);

        // All four continuously from reset: 0,1,2,3,0 and busy held high
        do_reset();
        set_req(2, 16'd100, 16'd100, 32'd1, 1'b1, 32'h0000_270F);
        set_req(3, 16'h8000, 16'h8000, 32'hFFFF_FFFF, 1'b0, 32'h3FFF_FFFF);
        expect_grant(0);
        expect_grant(1);
        expect_grant(2);
        expect_grant(3);
        expect_grant(0);
        @(posedge clk); #1;
        bus.req_valid = 4'b1111;
        for (int j = 1; j <= 8; j++) begin
            @(posedge clk); #1;
            if (j == 5) bus.req_valid = 4'b0000;
            chk_mode = 2;
            chk_val  = (j <= 7) ? 32'd1 : 32'd0;
            @(negedge clk); #1;
            chk_mode = 0;
        end

        // Reset with two operations in flight: both discarded, pointer back to 0
        expect_grant(1);
        expect_grant(2);
        @(posedge clk); #1;
        bus.req_valid = 4'b0110;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        rst      = 1'b1;
        chk_mode = 1;
        repeat (2) @(negedge clk);
        #1 chk_mode = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int j = 0; j < 6; j++) probe(4, 32'd0);
        expect_grant(0);
        drive(4'b1111, 1);

        // Requester 3 withdraws before being granted; then 0 wins from pointer 2
        expect_grant(1);
        drive(4'b1010, 1);
        expect_grant(0);
        drive(4'b0001, 1);
        idle(6);

`ifdef MULADD_ARB_LOCK_EN
        // Requester 1 locked for three operations while 2 waits
        do_reset();
        expect_grant(1);
        expect_grant(1);
        expect_grant(1);
        expect_grant(2);
        @(posedge clk); #1;
        bus.req_lock  = 4'b0010;
        bus.req_valid = 4'b0110;
        repeat (3) begin
            @(posedge clk); #1;
        end
        bus.req_valid = 4'b0100;
        bus.req_lock  = 4'b0000;
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        idle(6);
`endif

        for (int t = 0; t < 20 && rsp_q.size() != 0; t++) @(posedge clk);
        probe(5, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
